// File: rtl/alu_issue_fifo.sv
// ALU issue queue: operand/op/tag FIFO with valid/ready on both sides.
// Optional same-cycle empty bypass enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_op1,
    input  logic [DATA_WIDTH-1:0]   in_op2,
    input  logic [3:0]              in_opsel,
    input  logic [4:0]              in_shamt,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_op1,
    output logic [DATA_WIDTH-1:0]   out_op2,
    output logic [3:0]              out_opsel,
    output logic [4:0]              out_shamt,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_op1   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_op2   [DEPTH];
    logic [3:0]            mem_opsel [DEPTH];
    logic [4:0]            mem_shamt [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          stored_valid;
    logic          bypass;
    logic          do_push;
    logic          do_pop;
    logic [3:0]    head_opsel;

    assign stored_valid = (count != '0);
    assign in_ready     = (count < FULL) && !flush && !rst;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass = (count == '0) && !flush && !rst && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = stored_valid || bypass;
    assign do_push   = in_valid && in_ready && !bypass;
    assign do_pop    = stored_valid && out_ready && !flush;

    always_comb begin
        out_op1    = '0;
        out_op2    = '0;
        out_opsel  = '0;
        out_shamt  = '0;
        out_tag    = '0;
        head_opsel = '0;
        if (bypass) begin
            out_op1    = in_op1;
            out_op2    = in_op2;
            out_opsel  = in_opsel;
            out_shamt  = in_shamt;
            out_tag    = in_tag;
            head_opsel = in_opsel;
        end else if (stored_valid) begin
            out_op1    = mem_op1[rd_ptr];
            out_op2    = mem_op2[rd_ptr];
            out_opsel  = mem_opsel[rd_ptr];
            out_shamt  = mem_shamt[rd_ptr];
            out_tag    = mem_tag[rd_ptr];
            head_opsel = mem_opsel[rd_ptr];
        end
    end

    // Codes 1001..1110 are reserved; they travel through but get flagged.
    assign out_illegal = out_valid &&
                         (head_opsel >= 4'd9) && (head_opsel <= 4'd14);

    // Entry storage carries no reset; only pointers and count do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_op1[wr_ptr]   <= in_op1;
            mem_op2[wr_ptr]   <= in_op2;
            mem_opsel[wr_ptr] <= in_opsel;
            mem_shamt[wr_ptr] <= in_shamt;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
